iter_divider: RTL and testbench

ITER_DIVIDER -- requirements
Module: iter_divider

---
 rtl/iter_divider.sv | 144 ++++++++++++++
 tb/tb_iter_divider.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// ============================================================================
// Module   : iter_divider
// Purpose  : 32-bit signed/unsigned radix-2 restoring divider, one bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_en,
  input  logic        div_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_busy,
  output logic        div_complete
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_last_step;

  logic [4:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dsr;
  logic        r_q_neg;
  logic        r_r_neg;
  logic        r_div_zero;

  logic        w_dvd_neg;
  logic        w_dsr_neg;
  logic [31:0] w_dvd_mag;
  logic [31:0] w_dsr_mag;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_qbit;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_q_mag;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last_step = (r_cnt == 5'd31);
    case (r_state)
      S_IDLE: begin
        if (div_en) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last_step) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (div_en) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Negating 0x80000000 yields 0x80000000, which read unsigned is exactly 2^31.
  always_comb begin
    w_dvd_neg = div_signed & dividend[31];
    w_dsr_neg = div_signed & divisor[31];
    w_dvd_mag = w_dvd_neg ? (32'd0 - dividend) : dividend;
    w_dsr_mag = w_dsr_neg ? (32'd0 - divisor) : divisor;
  end

  // Borrow shows in bit 32 of the 33-bit trial subtraction.
  always_comb begin
    w_shift   = {r_rem, r_quo[31]};
    w_diff    = w_shift - {1'b0, r_dsr};
    w_qbit    = ~w_diff[32];
    w_rem_nxt = w_qbit ? w_diff[31:0] : w_shift[31:0];
    w_q_mag   = {r_quo[30:0], w_qbit};
    w_q_fix   = r_div_zero ? 32'hFFFF_FFFF
              : (r_q_neg ? (32'd0 - w_q_mag) : w_q_mag);
    w_r_fix   = r_r_neg ? (32'd0 - w_rem_nxt) : w_rem_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= 5'd0;
      r_rem        <= 32'd0;
      r_quo        <= 32'd0;
      r_dsr        <= 32'd0;
      r_q_neg      <= 1'b0;
      r_r_neg      <= 1'b0;
      r_div_zero   <= 1'b0;
      quotient     <= 32'd0;
      remainder    <= 32'd0;
      div_busy     <= 1'b0;
      div_complete <= 1'b0;
    end else begin
      div_busy     <= (w_state_nxt == S_BUSY);
      div_complete <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_cnt      <= 5'd0;
        r_rem      <= 32'd0;
        r_quo      <= w_dvd_mag;
        r_dsr      <= w_dsr_mag;
        r_q_neg    <= w_dvd_neg ^ w_dsr_neg;
        r_r_neg    <= w_dvd_neg;
        r_div_zero <= (divisor == 32'd0);
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 5'd1;
        r_rem <= w_rem_nxt;
        r_quo <= w_q_mag;
        if (w_last_step) begin
          quotient  <= w_q_fix;
          remainder <= w_r_fix;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iter_divider.sv
// ============================================================================
// Module   : tb_iter_divider
// Purpose  : Self-checking bench for iter_divider: vector table, corner sequences, random ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iter_divider;

  logic        clk;
  logic        reset;
  logic        div_en;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_busy;
  logic        div_complete;

  int checks;
  int errors;
  logic [31:0] prev_q;
  logic [31:0] prev_r;

  iter_divider dut (
    .clk          (clk),
    .reset        (reset),
    .div_en       (div_en),
    .div_signed   (div_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_busy     (div_busy),
    .div_complete (div_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain SystemVerilog arithmetic plus the divide-by-zero and overflow rules.
  function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
  endfunction

  // Called at the first falling edge after the accept edge, with c0 cycles already elapsed.
  task automatic wait_done(input int c0, output int lat);
    int c;
    c = c0;
    while (!div_complete && c < 40) begin
      chk("busy_high", {31'd0, div_busy}, 32'd1);
      chk("hold_q", quotient, prev_q);
      chk("hold_r", remainder, prev_r);
      @(negedge clk);
      c++;
    end
    lat = c - 1;
    chk("latency", lat, 32);
    chk("busy_low_at_done", {31'd0, div_busy}, 32'd0);
  endtask

  task automatic start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    div_en     = 1'b1;
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    @(negedge clk);
    div_en     = 1'b0;
    div_signed = ~sgn;
    dividend   = $urandom;
    divisor    = $urandom;
  endtask

  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er);
    int lat;
    start(sgn, a, b);
    wait_done(1, lat);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    prev_q = eq;
    prev_r = er;
    @(negedge clk);
    chk("complete_one_cycle", {31'd0, div_complete}, 32'd0);
    chk("idle_hold_q", quotient, eq);
  endtask

  vec_t vecs[9];

  initial begin
    int lat;
    bit seen;
    logic [31:0] eq, er, a, b;
    logic sgn;
    checks = 0;
    errors = 0;
    prev_q = 32'd0;
    prev_r = 32'd0;

    vecs[0] = '{1'b0, 32'd100,         32'd7,         32'd14,        32'd2};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 32'd7,           32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    vecs[3] = '{1'b1, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    vecs[4] = '{1'b0, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5] = '{1'b0, 32'd5,           32'd0,         32'hFFFF_FFFF, 32'd5};
    vecs[6] = '{1'b1, 32'hFFFF_FFFB,   32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB};
    vecs[7] = '{1'b0, 32'd9,           32'd3,         32'd3,         32'd0};
    vecs[8] = '{1'b1, 32'h8000_0000,   32'd1,         32'h8000_0000, 32'd0};

    // Reset with div_en held high: outputs clear and the request is ignored.
    reset      = 1'b1;
    div_en     = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    repeat (3) @(negedge clk);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_busy", {31'd0, div_busy}, 32'd0);
    chk("rst_complete", {31'd0, div_complete}, 32'd0);
    div_en = 1'b0;
    reset  = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", {31'd0, div_busy}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
    end

    // Mid-BUSY request is ignored; request in the DONE cycle chains immediately.
    @(negedge clk);
    div_en = 1'b1; div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    div_en = 1'b0;
    repeat (4) @(negedge clk);
    div_en = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    div_en = 1'b0;
    wait_done(6, lat);
    chk("ignored_q", quotient, 32'd14);
    chk("ignored_r", remainder, 32'd2);
    prev_q = 32'd14;
    prev_r = 32'd2;
    div_en = 1'b1; div_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    div_en = 1'b0;
    chk("b2b_busy", {31'd0, div_busy}, 32'd1);
    chk("b2b_complete_drop", {31'd0, div_complete}, 32'd0);
    wait_done(1, lat);
    chk("b2b_q", quotient, 32'd10);
    chk("b2b_r", remainder, 32'd0);
    prev_q = 32'd10;
    prev_r = 32'd0;
    @(negedge clk);

    // Reset during step 10 discards the operation at once.
    start(1'b0, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, div_busy}, 32'd0);
    chk("arst_complete", {31'd0, div_complete}, 32'd0);
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", remainder, 32'd0);
    #1 reset = 1'b0;
    prev_q = 32'd0;
    prev_r = 32'd0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (div_complete || div_busy) seen = 1'b1;
    end
    chk("no_complete_after_rst", {31'd0, seen}, 32'd0);
    do_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      model(sgn, a, b, eq, er);
      do_op(sgn, a, b, eq, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
